ps2_keyboard_rx: RTL and testbench
==================================

Name: ps2_keyboard_rx

Overview:
- PS/2 device-to-host receiver and scan-code decoder. It produces the keycode/key_make/key_ext triple consumed by the game datapath.
- Samples the raw keyboard ps2_clk/ps2_data lines, deserialises 11-bit frames and checks parity and stop bits.
- Folds the E0 (extended) and F0 (break) prefix bytes into flags, then presents one decoded key event per completed scan-code sequence.
- Receive only: never drives the PS/2 lines.

Parameters:
- TIMEOUT_CYCLES, 26'd50_000: clk cycles with no ps2_clk falling edge mid-frame before the partial frame is discarded (1 ms at 50 MHz).
- SYNC_STAGES, 2: synchroniser flip-flop depth on ps2_clk and ps2_data (minimum 2).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- ps2_clk  input  1  raw keyboard clock, asynchronous to clk, idles high.
- ps2_data  input  1  raw keyboard data, asynchronous to clk, idles high.
- keycode  output  8  last decoded scan code, prefix bytes removed.
- key_make  output  1  1 = press (make), 0 = release (break) for keycode.
- key_ext  output  1  1 = keycode was preceded by E0.
- key_valid  output  1  one-cycle strobe, asserted when keycode/key_make/key_ext update.
- frame_err  output  1  one-cycle strobe on parity error, stop-bit error or timeout.

Behaviour:
- Reset:
  - keycode=0, key_make=0, key_ext=0, key_valid=0, frame_err=0.
  - FSM=IDLE, ext_pending=0, brk_pending=0, timeout counter=0.
  - All synchroniser flops reset to 1 (line idle), so no false edge is seen on release.
  - Reset asserted mid-frame discards the frame immediately.
- Synchronisation and edge detection:
  - Both lines pass through SYNC_STAGES flops.
  - fall = (previous synced ps2_clk == 1) && (current synced ps2_clk == 0).
  - ps2_data is sampled from its synced copy in the same cycle fall is high.
- Frame format, per fall: start bit (0), D0..D7 LSB first, odd parity bit, stop bit (1).
- FSM states IDLE, DATA, PARITY, STOP:
  - IDLE: on fall with data=0, go to DATA with bit count 0. On fall with data=1 (spurious start), stay in IDLE with no error.
  - DATA: on fall, shift the data bit into bit [count]. After the 8th bit go to PARITY.
  - PARITY: on fall, capture the parity bit and go to STOP.
  - STOP: on fall, check the frame and return to IDLE:
    - If stop==1 and XOR(D7..D0, parity)==1, the byte is good and goes to the decoder.
    - Otherwise pulse frame_err, discard the byte, and clear ext_pending and brk_pending.
- Timeout:
  - The counter runs only outside IDLE and clears on every fall.
  - When it reaches TIMEOUT_CYCLES: return to IDLE, pulse frame_err, clear pending flags.
  - Counter reaching its limit and fall in the same cycle: fall wins, no timeout.
- Byte decoder, for each good byte:
  - 8'hE0: set ext_pending, no output change.
  - 8'hF0: set brk_pending, no output change.
  - Any other byte:
    - Load keycode=byte, key_make=~brk_pending, key_ext=ext_pending.
    - Pulse key_valid.
    - Clear both pending flags.
- Latency: key_valid and frame_err assert in the clk cycle after the cycle in which the stop-bit fall is detected, and last exactly one cycle.
- Holding and ordering:
  - keycode, key_make and key_ext hold their values between events; the datapath treats them as levels.
  - Repeated E0 or F0 prefixes are idempotent.
  - F0 before E0 is accepted; flags are order-independent.
- Minimum ps2_clk low/high time is well above SYNC_STAGES+1 clk cycles, so the block does no glitch filtering.

Decomposition:
- Shared package ps2_pkg:
  - PS2_PREFIX_EXT = 8'hE0.
  - PS2_PREFIX_BREAK = 8'hF0.
  - FSM state encoding (IDLE, DATA, PARITY, STOP).
  - Arrow-key codes 8'h6B, 8'h74, 8'h75, 8'h72, shared with the datapath.
- One sub-module, ps2_frame_rx:
  - Contains the synchroniser, edge detect, FSM, timeout and parity check.
  - Outputs byte[7:0], byte_valid strobe and err strobe.
- The top level holds the prefix-decoder registers and the output registers.

Test Plan:
- Make, plain key: frame 0x1C (parity 0) -> next cycle keycode=8'h1C, key_make=1, key_ext=0, key_valid pulse of 1 cycle, frame_err=0.
- Extended make: E0 (parity 0) then 74 (parity 1) -> a single key_valid pulse, after the 74 frame only; keycode=8'h74, key_make=1, key_ext=1.
- Extended break: E0, F0 (parity 1), 74 -> keycode=8'h74, key_make=0, key_ext=1. A following plain 0x1C frame gives key_ext=0, key_make=1.
- Parity error: 0x1C sent with parity 1 -> frame_err pulse, no key_valid, outputs keep their previous values. A pending E0 from before is cleared.
- Timeout: start bit plus 3 data bits, then a ps2_clk stall of TIMEOUT_CYCLES+10 -> one frame_err pulse and FSM back in IDLE. A following good 0x75 frame (parity 0) -> keycode=8'h75, key_valid pulse.
- Reset mid-frame: assert reset after 5 bits -> all outputs 0 asynchronously. After release, a full 0x72 frame (parity 1) decodes to keycode=8'h72 with no frame_err and no spurious key_valid from the aborted frame.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: prefix bytes, receiver FSM states, arrow-key codes.
package ps2_pkg;

  localparam logic [7:0] PS2_PREFIX_EXT   = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BREAK = 8'hF0;

  localparam logic [7:0] PS2_KEY_LEFT  = 8'h6B;
  localparam logic [7:0] PS2_KEY_RIGHT = 8'h74;
  localparam logic [7:0] PS2_KEY_UP    = 8'h75;
  localparam logic [7:0] PS2_KEY_DOWN  = 8'h72;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } ps2_state_t;

  // Odd parity holds when data bits plus parity bit contain an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_keyboard_rx_if.sv
// Decoded key-event bus between the PS/2 receiver and the game datapath.
interface ps2_keyboard_rx_if;
  logic [7:0] keycode;
  logic       key_make;
  logic       key_ext;
  logic       key_valid;
  logic       frame_err;

  modport master (output keycode, key_make, key_ext, key_valid, frame_err);
  modport slave  (input  keycode, key_make, key_ext, key_valid, frame_err);
endinterface

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: synchronises the raw lines, deserialises 11-bit frames,
// checks parity/stop and discards frames that stall mid-way.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter logic [25:0] TIMEOUT_CYCLES = 26'd50_000,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       err
);

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   clk_prev;
  logic                   clk_s;
  logic                   data_s;
  logic                   fall;

  ps2_state_t  state;
  ps2_state_t  state_n;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift;
  logic        par_bit;
  logic [25:0] tcount;
  logic        timeout;

  assign clk_s   = clk_sync[SYNC_STAGES-1];
  assign data_s  = data_sync[SYNC_STAGES-1];
  assign fall    = clk_prev & ~clk_s;
  assign timeout = (state != ST_IDLE) && !fall && (tcount == TIMEOUT_CYCLES);
  assign rx_byte = shift;

  // Synchroniser chains and previous-clock flop; all reset to the idle-high level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
      clk_prev  <= clk_s;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  // Next-state and frame-check strobes; a fall in the limit cycle beats the timeout.
  always_comb begin
    state_n    = state;
    byte_valid = 1'b0;
    err        = 1'b0;
    case (state)
      ST_IDLE:   if (fall && !data_s) state_n = ST_DATA;
      ST_DATA:   if (fall && bit_cnt == 3'd7) state_n = ST_PARITY;
      ST_PARITY: if (fall) state_n = ST_STOP;
      ST_STOP: begin
        if (fall) begin
          state_n = ST_IDLE;
          if (data_s && odd_parity_ok(shift, par_bit)) byte_valid = 1'b1;
          else                                         err        = 1'b1;
        end
      end
      default:   state_n = ST_IDLE;
    endcase
    if (timeout) begin
      state_n = ST_IDLE;
      err     = 1'b1;
    end
  end

  // Data shift register, bit counter, parity capture and stall counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt <= '0;
      shift   <= '0;
      par_bit <= 1'b0;
      tcount  <= '0;
    end else begin
      if (fall) begin
        case (state)
          ST_IDLE:   bit_cnt <= '0;
          ST_DATA: begin
            shift[bit_cnt] <= data_s;
            bit_cnt        <= bit_cnt + 3'd1;
          end
          ST_PARITY: par_bit <= data_s;
          default:   ;
        endcase
      end
      if (state_n == ST_IDLE || fall) tcount <= '0;
      else                            tcount <= tcount + 26'd1;
    end
  end

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver top: folds E0/F0 prefixes into flags and registers
// one decoded key event per completed scan-code sequence.
module ps2_keyboard_rx
  import ps2_pkg::*;
#(
  parameter logic [25:0] TIMEOUT_CYCLES = 26'd50_000,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ps2_clk,
  input  logic              ps2_data,
  ps2_keyboard_rx_if.master key_if
);

  logic [7:0] rx_byte;
  logic       byte_valid;
  logic       err;

  logic [7:0] keycode;
  logic       key_make;
  logic       key_ext;
  logic       key_valid;
  logic       frame_err;
  logic       ext_pending;
  logic       brk_pending;

  ps2_frame_rx #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES)
  ) u_frame_rx (
    .clk        (clk),
    .reset      (reset),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .rx_byte    (rx_byte),
    .byte_valid (byte_valid),
    .err        (err)
  );

  // Prefix flags and held key outputs; a bad frame drops any pending prefixes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      keycode     <= '0;
      key_make    <= 1'b0;
      key_ext     <= 1'b0;
      key_valid   <= 1'b0;
      frame_err   <= 1'b0;
      ext_pending <= 1'b0;
      brk_pending <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      frame_err <= err;
      if (err) begin
        ext_pending <= 1'b0;
        brk_pending <= 1'b0;
      end else if (byte_valid) begin
        if (rx_byte == PS2_PREFIX_EXT) begin
          ext_pending <= 1'b1;
        end else if (rx_byte == PS2_PREFIX_BREAK) begin
          brk_pending <= 1'b1;
        end else begin
          keycode     <= rx_byte;
          key_make    <= ~brk_pending;
          key_ext     <= ext_pending;
          key_valid   <= 1'b1;
          ext_pending <= 1'b0;
          brk_pending <= 1'b0;
        end
      end
    end
  end

  assign key_if.keycode   = keycode;
  assign key_if.key_make  = key_make;
  assign key_if.key_ext   = key_ext;
  assign key_if.key_valid = key_valid;
  assign key_if.frame_err = frame_err;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Randomised and directed bench for ps2_keyboard_rx against a scan-code reference model.
module tb_ps2_keyboard_rx;

  localparam logic [25:0] TMO  = 26'd300;
  localparam int unsigned HALF = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;

  ps2_keyboard_rx_if key_if ();

  ps2_keyboard_rx #(
    .TIMEOUT_CYCLES (TMO),
    .SYNC_STAGES    (2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .key_if   (key_if)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // Reference model state: last event plus pending prefix flags.
  logic [7:0] m_code = 8'h00;
  logic       m_make = 1'b0;
  logic       m_ext  = 1'b0;
  logic       m_e    = 1'b0;
  logic       m_b    = 1'b0;
  int unsigned exp_kv = 0;
  int unsigned exp_fe = 0;

  // Pulse observers, sampled on the falling edge.
  int unsigned kv_cnt = 0;
  int unsigned fe_cnt = 0;
  int unsigned wide_pulses = 0;
  logic kv_prev = 1'b0;
  logic fe_prev = 1'b0;

  always @(negedge clk) begin
    if (key_if.key_valid) kv_cnt++;
    if (key_if.frame_err) fe_cnt++;
    if ((key_if.key_valid && kv_prev) || (key_if.frame_err && fe_prev)) wide_pulses++;
    kv_prev = key_if.key_valid;
    fe_prev = key_if.frame_err;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    repeat (HALF) @(posedge clk);
    ps2_clk = 1'b0;
    repeat (HALF) @(posedge clk);
    ps2_clk = 1'b1;
  endtask

  // Model of one received byte: good bytes feed the scan-code decoder, bad ones drop prefixes.
  task automatic model_byte(input logic [7:0] d, input logic good);
    if (!good) begin
      exp_fe++;
      m_e = 1'b0;
      m_b = 1'b0;
    end else if (d == 8'hE0) begin
      m_e = 1'b1;
    end else if (d == 8'hF0) begin
      m_b = 1'b1;
    end else begin
      m_code = d;
      m_make = ~m_b;
      m_ext  = m_e;
      exp_kv++;
      m_e = 1'b0;
      m_b = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic bad_stop);
    logic par;
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    par = ((ones % 2) == 0) ^ bad_par;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(d[i]);
    ps2_bit(par);
    ps2_bit(~bad_stop);
    ps2_data = 1'b1;
    repeat (6) @(posedge clk);
    model_byte(d, !(bad_par || bad_stop));
  endtask

  task automatic check_state(input string tag);
    #1;
    check({tag, ".kv_count"}, kv_cnt, exp_kv);
    check({tag, ".fe_count"}, fe_cnt, exp_fe);
    check({tag, ".keycode"}, {24'h0, key_if.keycode}, {24'h0, m_code});
    check({tag, ".key_make"}, {31'h0, key_if.key_make}, {31'h0, m_make});
    check({tag, ".key_ext"}, {31'h0, key_if.key_ext}, {31'h0, m_ext});
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] k;
    int unsigned sel;

    repeat (3) @(posedge clk);
    #1;
    check("reset.keycode", {24'h0, key_if.keycode}, 32'h0);
    check("reset.strobes", {30'h0, key_if.key_valid, key_if.frame_err}, 32'h0);
    check("reset.flags", {30'h0, key_if.key_make, key_if.key_ext}, 32'h0);
    reset = 1'b0;
    repeat (4) @(posedge clk);

    send_frame(8'h1C, 1'b0, 1'b0);
    check_state("make_1c");

    send_frame(8'hE0, 1'b0, 1'b0);
    check_state("ext_prefix");
    send_frame(8'h74, 1'b0, 1'b0);
    check_state("ext_make");

    send_frame(8'hE0, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h74, 1'b0, 1'b0);
    check_state("ext_break");
    send_frame(8'h1C, 1'b0, 1'b0);
    check_state("plain_after");

    send_frame(8'hE0, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b1, 1'b0);
    check_state("parity_err");
    send_frame(8'h1C, 1'b0, 1'b0);
    check_state("ext_cleared");

    ps2_bit(1'b0);
    for (int i = 0; i < 3; i++) ps2_bit(1'b1);
    repeat (int'(TMO) + 10) @(posedge clk);
    exp_fe++;
    m_e = 1'b0;
    m_b = 1'b0;
    check_state("timeout");
    send_frame(8'h75, 1'b0, 1'b0);
    check_state("after_timeout");

    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("async_rst.keycode", {24'h0, key_if.keycode}, 32'h0);
    check("async_rst.flags", {30'h0, key_if.key_make, key_if.key_ext}, 32'h0);
    m_code = 8'h00;
    m_make = 1'b0;
    m_ext  = 1'b0;
    m_e    = 1'b0;
    m_b    = 1'b0;
    repeat (3) @(posedge clk);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    send_frame(8'h72, 1'b0, 1'b0);
    check_state("post_reset");

    for (int unsigned s = 0; s < 40; s++) begin
      sel = $urandom_range(0, 5);
      if (sel == 1 || sel == 3) send_frame(8'hE0, 1'b0, 1'b0);
      if (sel >= 2) send_frame(8'hF0, 1'b0, 1'b0);
      if (sel == 4) send_frame(8'hE0, 1'b0, 1'b0);
      if (sel == 5) send_frame(8'hF0, $urandom_range(0, 3) == 0, 1'b0);
      do k = 8'($urandom_range(0, 255)); while (k == 8'hE0 || k == 8'hF0);
      send_frame(k, $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0);
      check_state("rand");
    end

    check("pulse_width", wide_pulses, 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
